// File: rtl/digit_scanner_if.sv
// rtl/digit_scanner_if.sv - control and digit-select bundle between the display datapath and digit_scanner
interface digit_scanner_if #(
    parameter int LEN   = 4,
    parameter int CNT_W = 16
);
    localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;

    logic [CNT_W-1:0] period;
    logic [LEN-1:0]   mask;
    logic             dir;
    logic             hold;
    logic [LEN-1:0]   sel;
    logic [IDX_W-1:0] idx;
    logic             blank;
    logic             step;

    modport master (
        output period, mask, dir, hold,
        input  sel, idx, blank, step
    );

    modport slave (
        input  period, mask, dir, hold,
        output sel, idx, blank, step
    );
endinterface

// File: rtl/digit_scanner.sv
// rtl/digit_scanner.sv - one-hot multiplexed display scanner with blanking, mask, direction and hold
module digit_scanner #(
    parameter int LEN   = 4,
    parameter int CNT_W = 16,
    parameter int BLANK = 8
) (
    input  logic          clk,
    input  logic          rst,
    digit_scanner_if.slave bus
);
    localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W:0] BLANK_C = (CNT_W+1)'(BLANK);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] cand_idx;
    logic             found;
    logic             adv;
    logic             blank_d;
    logic [LEN-1:0]   sel_d;
    int               cand;

    // Walk k from LEN down to 1 so the smallest enabled distance is the last one kept;
    // k = LEN is the current digit, which lets a lone enabled digit reselect itself.
    always_comb begin
        found    = 1'b0;
        cand_idx = idx_q;
        cand     = 0;
        for (int k = LEN; k >= 1; k--) begin
            cand = bus.dir ? ((int'(idx_q) + k) % LEN) : ((int'(idx_q) + LEN - k) % LEN);
            if (bus.mask[IDX_W'(cand)]) begin
                found    = 1'b1;
                cand_idx = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        count_d = count_q;
        idx_d   = idx_q;
        adv     = 1'b0;
        if (!bus.hold) begin
            if (count_q >= bus.period) begin
                count_d = '0;
                if (found) begin
                    idx_d = cand_idx;
                    adv   = 1'b1;
                end
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
        blank_d = ({1'b0, count_d} < BLANK_C) | ~bus.mask[idx_d];
        sel_d   = blank_d ? '0 : (LEN'(1) << idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            idx_q     <= IDX_W'(LEN - 1);
            bus.sel   <= '0;
            bus.blank <= 1'b1;
            bus.step  <= 1'b0;
        end else begin
            count_q   <= count_d;
            idx_q     <= idx_d;
            bus.sel   <= sel_d;
            bus.blank <= blank_d;
            bus.step  <= adv;
        end
    end

    assign bus.idx = idx_q;
endmodule

// File: tb/tb_digit_scanner.sv
// tb/tb_digit_scanner.sv - randomized and directed bench for digit_scanner against a slot-level model
module tb_digit_scanner;
    localparam int LEN   = 4;
    localparam int CNT_W = 16;
    localparam int BLANK = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    digit_scanner_if #(.LEN(LEN), .CNT_W(CNT_W)) bus();
    digit_scanner #(.LEN(LEN), .CNT_W(CNT_W), .BLANK(BLANK)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int m_count;
    int m_idx;
    logic [3:0] e_sel;
    logic [1:0] e_idx;
    logic       e_blank;
    logic       e_step;

    // Model: position within the slot and current digit, advanced once per clock.
    task automatic tick();
        logic [3:0] mk;
        @(posedge clk);
        mk = bus.mask;
        e_step = 1'b0;
        if (rst) begin
            m_count = 0;
            m_idx   = LEN - 1;
        end else if (!bus.hold) begin
            if (m_count >= int'(bus.period)) begin
                m_count = 0;
                for (int k = 1; k <= LEN; k++) begin
                    int c;
                    c = bus.dir ? (m_idx + k) % LEN : (m_idx - k + LEN) % LEN;
                    if (mk[2'(c)]) begin
                        m_idx  = c;
                        e_step = 1'b1;
                        break;
                    end
                end
            end else begin
                m_count++;
            end
        end
        if (rst) begin
            e_blank = 1'b1;
            e_sel   = 4'b0;
        end else begin
            e_blank = (m_count < BLANK) || !mk[2'(m_idx)];
            e_sel   = e_blank ? 4'b0 : 4'(1 << m_idx);
        end
        e_idx = 2'(m_idx);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.period = 16'd5; bus.mask = 4'b1111; bus.dir = 1'b0; bus.hold = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({bus.sel, bus.idx, bus.blank, bus.step} !== {4'b0000, 2'd3, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset: got sel=%b idx=%0d blank=%b step=%b, want sel=0000 idx=3 blank=1 step=0",
                     bus.sel, bus.idx, bus.blank, bus.step);
        end
    endtask

    task automatic test_scan_desc();
        int expq[$] = '{2, 1, 0, 3, 2};
        int last = -1;
        int lit = 0;
        int want;
        rst = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick();
            n_vec++;
            if ({bus.sel, bus.idx, bus.blank, bus.step} !== {e_sel, e_idx, e_blank, e_step}) begin
                n_err++;
                $display("FAIL scan_desc: cyc %0d got sel=%b idx=%0d blank=%b step=%b, want sel=%b idx=%0d blank=%b step=%b",
                         cyc, bus.sel, bus.idx, bus.blank, bus.step, e_sel, e_idx, e_blank, e_step);
            end
            if (bus.sel != 0) lit++;
            if (bus.step === 1'b1) begin
                if (expq.size() > 0) begin
                    want = expq.pop_front();
                    n_vec++;
                    if (int'(bus.idx) != want) begin
                        n_err++;
                        $display("FAIL scan_desc_order: got idx=%0d want %0d", bus.idx, want);
                    end
                end
                if (last >= 0) begin
                    n_vec++;
                    if (cyc - last != 6) begin
                        n_err++;
                        $display("FAIL scan_desc_gap: got %0d cycles between steps want 6", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        n_vec++;
        if (lit != 20) begin
            n_err++;
            $display("FAIL scan_desc_lit: got %0d lit cycles want 20", lit);
        end
    endtask

    task automatic test_mask_dir();
        int steps = 0;
        bus.mask = 4'b1010; bus.dir = 1'b1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            tick();
            n_vec++;
            if ({bus.sel, bus.idx, bus.blank, bus.step} !== {e_sel, e_idx, e_blank, e_step}) begin
                n_err++;
                $display("FAIL mask_dir: got sel=%b idx=%0d blank=%b step=%b, want sel=%b idx=%0d blank=%b step=%b",
                         bus.sel, bus.idx, bus.blank, bus.step, e_sel, e_idx, e_blank, e_step);
            end
            n_vec++;
            if ((bus.sel & 4'b0101) != 4'b0000) begin
                n_err++;
                $display("FAIL mask_dir_skip: got sel=%b, want no bit 0 or 2", bus.sel);
            end
            if (bus.step === 1'b1) steps++;
        end
        n_vec++;
        if (steps != 4) begin
            n_err++;
            $display("FAIL mask_dir_steps: got %0d steps want 4", steps);
        end
    endtask

    task automatic test_hold();
        int guard = 0;
        int rel = 0;
        bus.mask = 4'b1111; bus.dir = 1'b0;
        while (!(m_count == 3 && m_idx == 2) && guard < 100) begin
            tick();
            guard++;
        end
        n_vec++;
        if (guard >= 100) begin
            n_err++;
            $display("FAIL hold_reach: got no count=3 idx=2 within 100 cycles, want reached");
        end
        bus.hold = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            n_vec++;
            if ({bus.sel, bus.idx, bus.blank, bus.step} !== {4'b0100, 2'd2, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL hold_frozen: got sel=%b idx=%0d blank=%b step=%b, want sel=0100 idx=2 blank=0 step=0",
                         bus.sel, bus.idx, bus.blank, bus.step);
            end
        end
        bus.hold = 1'b0;
        do begin
            tick();
            rel++;
        end while (bus.step !== 1'b1 && rel < 20);
        n_vec++;
        if (rel != 3 || bus.idx !== 2'd1) begin
            n_err++;
            $display("FAIL hold_release: got step after %0d cycles idx=%0d, want 3 cycles idx=1", rel, bus.idx);
        end
    endtask

    task automatic test_mask_zero();
        int guard = 0;
        bus.mask = 4'b0000;
        for (int cyc = 0; cyc < 18; cyc++) begin
            tick();
            n_vec++;
            if ({bus.sel, bus.idx, bus.blank, bus.step} !== {4'b0000, e_idx, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL mask_zero: got sel=%b idx=%0d blank=%b step=%b, want sel=0000 idx=%0d blank=1 step=0",
                         bus.sel, bus.idx, bus.blank, bus.step, e_idx);
            end
        end
        bus.mask = 4'b0001;
        do begin
            tick();
            guard++;
        end while (bus.step !== 1'b1 && guard < 20);
        n_vec++;
        if (bus.step !== 1'b1 || bus.idx !== 2'd0) begin
            n_err++;
            $display("FAIL mask_one: got step=%b idx=%0d, want step=1 idx=0", bus.step, bus.idx);
        end
    endtask

    task automatic test_period_shrink();
        int guard = 0;
        int steps = 0;
        bus.mask = 4'b1111; bus.period = 16'd100;
        while (m_count != 50 && guard < 300) begin
            tick();
            guard++;
        end
        bus.period = 16'd3;
        tick();
        n_vec++;
        if (bus.step !== 1'b1 || e_step !== 1'b1 || bus.idx !== e_idx) begin
            n_err++;
            $display("FAIL period_shrink: got step=%b idx=%0d, want step=1 idx=%0d", bus.step, bus.idx, e_idx);
        end
        for (int cyc = 0; cyc < 16; cyc++) begin
            tick();
            n_vec++;
            if ({bus.sel, bus.idx, bus.blank, bus.step} !== {e_sel, e_idx, e_blank, e_step}) begin
                n_err++;
                $display("FAIL period_short: got sel=%b idx=%0d blank=%b step=%b, want sel=%b idx=%0d blank=%b step=%b",
                         bus.sel, bus.idx, bus.blank, bus.step, e_sel, e_idx, e_blank, e_step);
            end
            if (bus.step === 1'b1) steps++;
        end
        n_vec++;
        if (steps != 4) begin
            n_err++;
            $display("FAIL period_short_steps: got %0d steps want 4", steps);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (!(m_idx == 1 && m_count == 2) && guard < 100) begin
            tick();
            guard++;
        end
        bus.hold = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({bus.sel, bus.idx, bus.blank, bus.step} !== {4'b0000, 2'd3, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid: got sel=%b idx=%0d blank=%b step=%b, want sel=0000 idx=3 blank=1 step=0",
                     bus.sel, bus.idx, bus.blank, bus.step);
        end
        bus.hold = 1'b0;
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 15) == 0) bus.period = 16'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0)  bus.mask   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) bus.dir    = ~bus.dir;
            bus.hold = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            tick();
            n_vec++;
            if ({bus.sel, bus.idx, bus.blank, bus.step} !== {e_sel, e_idx, e_blank, e_step}) begin
                n_err++;
                $display("FAIL random: cyc %0d got sel=%b idx=%0d blank=%b step=%b, want sel=%b idx=%0d blank=%b step=%b",
                         cyc, bus.sel, bus.idx, bus.blank, bus.step, e_sel, e_idx, e_blank, e_step);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_desc();
        test_mask_dir();
        test_hold();
        test_mask_zero();
        test_period_shrink();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
